alu_arbiter: RTL and testbench

Shares one registered 32-bit ALU (3-bit opcode, one-cycle result register, zero flag) among `NUM_REQ` requesters. It arbitrates requests round-robin and issues one operation at a time. It holds the ALU operands stable for the full ALU latency, captures the result and zero flag, and returns them with the requester's ID over a valid/ready response channel. It sits between the issue logic of the sequencing units and the ALU instance.

---
 rtl/alu_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NUM_REQ requesters. Requests are granted round-robin and answered over a valid/ready response channel.
// Define ALU_ARB_PRIO_EN to give requester 0 fixed top priority. Requesters 1..NUM_REQ-1 then rotate among themselves.
module alu_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 1,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]  req_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [2:0]            alu_op,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero
);

  localparam int CNT_W = $clog2(ALU_LATENCY + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

`ifdef ALU_ARB_PRIO_EN
  localparam logic [ID_W-1:0] RR_RESET = ID_W'(1);
`else
  localparam logic [ID_W-1:0] RR_RESET = '0;
`endif

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  next_ptr;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [2:0]       sel_op;

  // The second loop overrides the first, so the lowest index at or above rr_ptr wins.
  // If no such index exists, the lowest wrapped index below rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
`ifdef ALU_ARB_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 1; i--) begin
      if (req_valid[i] && (i < int'(rr_ptr))) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 1; i--) begin
      if (req_valid[i] && (i >= int'(rr_ptr))) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
    if (req_valid[0]) begin
      grant_found = 1'b1;
      grant_idx   = '0;
    end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i < int'(rr_ptr))) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(rr_ptr))) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
`endif
  end

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_a        = req_a[32*i +: 32];
        sel_b        = req_b[32*i +: 32];
        sel_op       = req_op[3*i +: 3];
        req_ready[i] = (state == S_IDLE) && !rst && grant_found;
      end
    end
  end

  // In priority mode, grants to requester 0 leave the rotation pointer untouched.
  always_comb begin
`ifdef ALU_ARB_PRIO_EN
    if (rsp_id == '0)
      next_ptr = rr_ptr;
    else if (int'(rsp_id) == NUM_REQ - 1)
      next_ptr = ID_W'(1);
    else
      next_ptr = rsp_id + ID_W'(1);
`else
    if (int'(rsp_id) == NUM_REQ - 1)
      next_ptr = '0;
    else
      next_ptr = rsp_id + ID_W'(1);
`endif
  end

  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= RR_RESET;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
            rsp_id <= grant_idx;
            cnt    <= CNT_W'(ALU_LATENCY);
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter. It uses a default instance plus an ALU_LATENCY=3 instance, each driven by its own behavioural ALU.
// Build with ALU_ARB_PRIO_EN defined to exercise the fixed-priority arbitration instead of the round-robin fairness test.
module tb_alu_arbiter;

  logic         clk = 1'b0;
  logic         rst;

  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic [11:0]  req_op;
  logic [31:0]  alu_a, alu_b;
  logic [2:0]   alu_op;
  logic [31:0]  alu_result = '0;
  logic         alu_zero = 1'b0;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic         rsp_zero;

  logic [3:0]   r3_valid, r3_ready;
  logic [127:0] r3_a, r3_b;
  logic [11:0]  r3_op;
  logic [31:0]  r3_alu_a, r3_alu_b;
  logic [2:0]   r3_alu_op;
  logic [31:0]  r3_alu_result = '0;
  logic         r3_alu_zero = 1'b0;
  logic         r3_rsp_valid, r3_rsp_ready;
  logic [1:0]   r3_rsp_id;
  logic [31:0]  r3_rsp_result;
  logic         r3_rsp_zero;
  logic [31:0]  p3_s1 = '0, p3_s2 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  alu_arbiter #(.ALU_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(r3_valid), .req_ready(r3_ready),
    .req_a(r3_a), .req_b(r3_b), .req_op(r3_op),
    .alu_a(r3_alu_a), .alu_b(r3_alu_b), .alu_op(r3_alu_op),
    .alu_result(r3_alu_result), .alu_zero(r3_alu_zero),
    .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready),
    .rsp_id(r3_rsp_id), .rsp_result(r3_rsp_result), .rsp_zero(r3_rsp_zero)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return b;
    endcase
  endfunction

  // Single-stage ALU for the default instance, three-stage pipeline for dut3
  always @(posedge clk) begin
    alu_result <= alu_f(alu_a, alu_b, alu_op);
    alu_zero   <= (alu_f(alu_a, alu_b, alu_op) == 32'd0);
    p3_s1      <= alu_f(r3_alu_a, r3_alu_b, r3_alu_op);
    p3_s2      <= p3_s1;
    r3_alu_result <= p3_s2;
    r3_alu_zero   <= (p3_s2 == 32'd0);
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[3*i +: 3]  = op;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'hF;
    req_a = '0; req_b = '0; req_op = '0;
    rsp_ready = 1'b1;
    r3_valid = '0; r3_a = '0; r3_b = '0; r3_op = '0;
    r3_rsp_ready = 1'b1;
    next_cycle;
    next_cycle;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if ({alu_a, alu_b, alu_op} !== 67'd0) begin errors++; $display("[TB] FAIL reset_alu_regs: got a=%0h b=%0h op=%0d expected zeros", alu_a, alu_b, alu_op); end
    checks++; if ({rsp_id, rsp_result, rsp_zero} !== 35'd0) begin errors++; $display("[TB] FAIL reset_rsp_regs: got id=%0d res=%0h z=%b expected zeros", rsp_id, rsp_result, rsp_zero); end
    checks++; if (r3_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_r3_rsp_valid: got %b expected 0", r3_rsp_valid); end
    next_cycle;
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single_op;
    int seen;
    set_req(2, 32'd5, 32'd3, 3'b000);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL single_ready: got %b expected 0100", req_ready); end
    next_cycle;
    req_valid = '0;
    seen = 0;
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = c; else next_cycle;
    end
    checks++; if (seen !== 3) begin errors++; $display("[TB] FAIL single_latency: got cycle %0d expected 3", seen); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("[TB] FAIL single_id: got %0d expected 2", rsp_id); end
    checks++; if (rsp_result !== 32'd8 || rsp_zero !== 1'b0) begin errors++; $display("[TB] FAIL single_result: got %0d z=%b expected 8 z=0", rsp_result, rsp_zero); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd3) begin errors++; $display("[TB] FAIL single_operands: got a=%0d b=%0d expected 5 3", alu_a, alu_b); end
    next_cycle;
  endtask

  task automatic test_zero_backpressure;
    int seen;
    set_req(0, 32'd7, 32'd7, 3'b001);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL bp_grant: got %b expected 0001", req_ready); end
    next_cycle;
    set_req(1, 32'd10, 32'd3, 3'b000);
    req_valid = 4'b0010;
    seen = 0;
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = c;
      else begin
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_exec_ready: got %b expected 0000", req_ready); end
        next_cycle;
      end
    end
    checks++; if (seen !== 3) begin errors++; $display("[TB] FAIL bp_latency: got cycle %0d expected 3", seen); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 2'd0) begin
        errors++; $display("[TB] FAIL bp_hold: got v=%b res=%0h z=%b id=%0d expected v=1 res=0 z=1 id=0", rsp_valid, rsp_result, rsp_zero, rsp_id);
      end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_resp_ready: got %b expected 0000", req_ready); end
      next_cycle;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_handshake_ready: got %b expected 0000", req_ready); end
    next_cycle;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL bp_after_ready: got %b expected 0010", req_ready); end
    next_cycle;
    req_valid = '0;
    seen = 0;
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = c; else next_cycle;
    end
    checks++; if (seen !== 3 || rsp_id !== 2'd1 || rsp_result !== 32'd13) begin
      errors++; $display("[TB] FAIL bp_second_op: got cycle=%0d id=%0d res=%0d expected 3 1 13", seen, rsp_id, rsp_result);
    end
    next_cycle;
  endtask

  task automatic test_fairness;
    int got;
    int seen;
    int e;
    rst = 1'b1;
    next_cycle;
    next_cycle;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 32'(100 * i + 1), 32'(i), 3'b000);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      e = n % 4;
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
        @(negedge clk);
        if (req_ready != 4'b0000) got = 1; else next_cycle;
      end
      checks++; if (req_ready !== (4'b0001 << e)) begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", n, req_ready, 4'b0001 << e); end
      next_cycle;
      seen = 0;
      for (int c = 1; c <= 10 && seen == 0; c++) begin
        @(negedge clk);
        if (rsp_valid) seen = c; else next_cycle;
      end
      checks++; if (seen !== 3 || rsp_id !== 2'(e) || rsp_result !== 32'(101 * e + 1)) begin
        errors++; $display("[TB] FAIL rr_rsp[%0d]: got cycle=%0d id=%0d res=%0d expected 3 %0d %0d", n, seen, rsp_id, rsp_result, e, 101 * e + 1);
      end
      next_cycle;
    end
    req_valid = '0;
  endtask

  task automatic test_operand_hold;
    int seen;
    r3_a[63:32] = 32'd20;
    r3_b[63:32] = 32'd22;
    r3_op[5:3]  = 3'b000;
    r3_valid = 4'b0010;
    r3_rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (r3_ready !== 4'b0010) begin errors++; $display("[TB] FAIL hold_grant: got %b expected 0010", r3_ready); end
    next_cycle;
    r3_a[63:32] = 32'd999;
    seen = 0;
    for (int c = 1; c <= 12 && seen == 0; c++) begin
      @(negedge clk);
      if (r3_rsp_valid) seen = c;
      else begin
        checks++; if (r3_alu_a !== 32'd20) begin errors++; $display("[TB] FAIL hold_alu_a[%0d]: got %0d expected 20", c, r3_alu_a); end
        next_cycle;
      end
    end
    checks++; if (seen !== 5) begin errors++; $display("[TB] FAIL hold_latency: got cycle %0d expected 5", seen); end
    checks++; if (r3_rsp_result !== 32'd42 || r3_rsp_id !== 2'd1 || r3_rsp_zero !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_result: got res=%0d id=%0d z=%b expected 42 1 0", r3_rsp_result, r3_rsp_id, r3_rsp_zero);
    end
    r3_valid = '0;
    next_cycle;
  endtask

  task automatic test_reset_mid_op;
    set_req(3, 32'd1, 32'd1, 3'b000);
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL midrst_grant: got %b expected 1000", req_ready); end
    next_cycle;
    rst = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_ready_in_reset: got %b expected 0000", req_ready); end
    next_cycle;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || alu_a !== 32'd0 || rsp_id !== 2'd0) begin
      errors++; $display("[TB] FAIL midrst_state: got v=%b a=%0d id=%0d expected 0 0 0", rsp_valid, alu_a, rsp_id);
    end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_rr_ptr: got %b expected 0001", req_ready); end
    req_valid = '0;
    for (int c = 0; c < 8; c++) begin
      next_cycle;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_rsp[%0d]: got %b expected 0", c, rsp_valid); end
    end
    next_cycle;
  endtask

`ifdef ALU_ARB_PRIO_EN
  task automatic test_priority;
    int got;
    int seen;
    int e;
    rst = 1'b1;
    next_cycle;
    next_cycle;
    rst = 1'b0;
    set_req(0, 32'd1, 32'd2, 3'b000);
    set_req(3, 32'd4, 32'd4, 3'b001);
    rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      e = (n < 3) ? 0 : 3;
      req_valid = (n < 3) ? 4'b1001 : 4'b1000;
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
        @(negedge clk);
        if (req_ready != 4'b0000) got = 1; else next_cycle;
      end
      checks++; if (req_ready !== (4'b0001 << e)) begin errors++; $display("[TB] FAIL prio_grant[%0d]: got %b expected %b", n, req_ready, 4'b0001 << e); end
      next_cycle;
      req_valid = (n < 2) ? 4'b1001 : 4'b1000;
      seen = 0;
      for (int c = 1; c <= 10 && seen == 0; c++) begin
        @(negedge clk);
        if (rsp_valid) seen = c; else next_cycle;
      end
      checks++; if (seen !== 3 || rsp_id !== 2'(e)) begin errors++; $display("[TB] FAIL prio_rsp[%0d]: got cycle=%0d id=%0d expected 3 %0d", n, seen, rsp_id, e); end
      next_cycle;
    end
    req_valid = '0;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset;
    test_single_op;
    test_zero_backpressure;
`ifndef ALU_ARB_PRIO_EN
    test_fairness;
`endif
    test_operand_hold;
    test_reset_mid_op;
`ifdef ALU_ARB_PRIO_EN
    test_priority;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
